// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes a - b - bin one bit per cycle, LSB first,
// with a start/done handshake and registered, held results.
module serial_sub #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic             x, y, diff, new_br;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    x        = a_sh_q[0];
    y        = b_sh_q[0];
    diff     = x ^ y ^ br_q;
    new_br   = (~x & y) | (~(x ^ y) & br_q);
    res_next = {diff, res_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    d_d     = d_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = new_br;
        res_d  = res_next;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          d_d     = res_next;
          bout_d  = new_br;
          // Borrow into the MSB differs from borrow out of it on signed overflow.
          ovf_d   = br_q ^ new_br;
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);
  assign d    = d_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// Directed, table-driven bench for serial_sub (WIDTH=4) plus hand-written
// sequences for mid-operation start, back-to-back restart and reset abort.
module tb_serial_sub;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bin = 1'b0;
  logic             busy, done, bout, ovf;
  logic [WIDTH-1:0] d;

  int npass = 0;
  int ntotal = 0;

  serial_sub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] exp_d;
    logic             exp_bout;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int actual, input int expected);
    ntotal++;
    if (actual == expected) npass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Start at a negedge, scramble inputs after acceptance, count busy cycles
  // until done (bounded), then check results.
  task automatic run_op(input vec_t v, input string tag);
    int  busy_cnt;
    bit  seen;
    busy_cnt = 0;
    seen = 0;
    a = v.a; b = v.b; bin = v.bin; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = ~v.a; b = ~v.b; bin = ~v.bin;
    for (int k = 0; k < 12; k++) begin
      if (done) begin seen = 1; break; end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    check({tag, " done_seen"}, int'(seen), 1);
    check({tag, " busy_cycles"}, busy_cnt, WIDTH);
    check({tag, " busy_in_done"}, int'(busy), 0);
    check({tag, " d"}, int'(d), int'(v.exp_d));
    check({tag, " bout"}, int'(bout), int'(v.exp_bout));
    check({tag, " ovf"}, int'(ovf), int'(v.exp_ovf));
    @(negedge clk);
    check({tag, " done_one_cycle"}, int'(done), 0);
    check({tag, " d_held"}, int'(d), int'(v.exp_d));
  endtask

  initial begin
    int k;
    bit seen;
    vecs[0] = '{4'b0110, 4'b0101, 1'b0, 4'b0001, 1'b0, 1'b0};
    vecs[1] = '{4'b0000, 4'b0001, 1'b1, 4'b1110, 1'b1, 1'b0};
    vecs[2] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0};
    vecs[3] = '{4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1};
    vecs[4] = '{4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1};
    vecs[5] = '{4'b0101, 4'b0011, 1'b1, 4'b0001, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset d", int'(d), 0);
    check("reset bout", int'(bout), 0);
    check("reset ovf", int'(ovf), 0);

    for (int i = 0; i < 6; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Mid-operation start is ignored; start held through DONE restarts.
    a = 4'b0110; b = 4'b0101; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 4'b1111; b = 4'b0000; bin = 1'b0;
    seen = 0;
    for (k = 0; k < 12; k++) begin
      if (done) begin seen = 1; break; end
      @(negedge clk);
    end
    check("hold first done_seen", int'(seen), 1);
    check("hold first d", int'(d), 4'b0001);
    check("hold first bout", int'(bout), 0);
    seen = 0;
    for (k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        check("restart busy", int'(busy), 1);
      end
      if (done) begin seen = 1; break; end
    end
    check("restart done_seen", int'(seen), 1);
    check("restart spacing", k, WIDTH + 1);
    check("restart d", int'(d), 4'b1111);
    check("restart bout", int'(bout), 0);
    check("restart ovf", int'(ovf), 0);
    @(negedge clk);

    // Reset mid-operation aborts immediately with no done pulse.
    a = 4'b0110; b = 4'b0101; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort d", int'(d), 0);
    check("abort bout", int'(bout), 0);
    check("abort ovf", int'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    check("abort no_activity", int'(seen), 0);
    run_op(vecs[0], "post_reset");

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
